// File: rtl/data_memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_arbiter_pkg
// Purpose  : Shared types and default sizing for the data memory arbiter.
//            Holds the dump FSM state encoding and the default word width,
//            address width, memory depth and starvation limit.
// Revision : 1.0 - initial release
// ============================================================================
package data_memory_arbiter_pkg;

  localparam int DEFAULT_MEMORY_WIDTH = 32;
  localparam int DEFAULT_NB_ADDR      = 7;
  localparam int DEFAULT_MEMORY_DEPTH = 128;
  localparam int DEFAULT_STARVE_LIMIT = 4;

  // Dump sequencer states, explicit 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DONE    = 3'd4
  } dump_state_t;

  // A dump is in progress from the first read request up to the final
  // handshake; the DONE cycle only carries the completion pulse.
  function automatic logic dump_state_busy(input dump_state_t st);
    return (st == ST_ISSUE) || (st == ST_CAPTURE) || (st == ST_HOLD);
  endfunction

endpackage : data_memory_arbiter_pkg
`default_nettype wire

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_arbiter
// Purpose  : Shares a single-port-read / single-port-write data memory
//            between a CPU and a memory-dump engine. The write port belongs
//            to the CPU outright; only the read port is arbitrated. The dump
//            engine walks addresses 0..MEMORY_DEPTH-1 and presents each word
//            on a valid/ready handshake.
// Options  : DMEM_ARB_FAIR_EN - when defined, a starvation counter forces a
//            dump grant after STARVE_LIMIT consecutive CPU wins in ISSUE.
//            When undefined, the CPU has strict priority.
// Ports    : i_clock, i_reset (async, active-low)
//            CPU  : i_cpu_read, i_cpu_write, i_cpu_addr, i_cpu_wdata,
//                   o_cpu_stall, o_cpu_rdata, o_cpu_rvalid
//            Dump : i_dump_start, i_dump_ready, o_dump_valid, o_dump_addr,
//                   o_dump_data, o_dump_busy, o_dump_done
//            Mem  : o_mem_write_addr, o_mem_read_addr, o_mem_data,
//                   o_mem_write_enable, o_mem_read_enable, i_mem_data
//                   (registered read, 1-cycle latency, read-first)
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int MEMORY_WIDTH = DEFAULT_MEMORY_WIDTH,
  parameter int NB_ADDR      = DEFAULT_NB_ADDR,
  parameter int MEMORY_DEPTH = DEFAULT_MEMORY_DEPTH,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  // CPU port
  input  logic                    i_cpu_read,
  input  logic                    i_cpu_write,
  input  logic [NB_ADDR-1:0]      i_cpu_addr,
  input  logic [MEMORY_WIDTH-1:0] i_cpu_wdata,
  output logic                    o_cpu_stall,
  output logic [MEMORY_WIDTH-1:0] o_cpu_rdata,
  output logic                    o_cpu_rvalid,
  // Dump port
  input  logic                    i_dump_start,
  input  logic                    i_dump_ready,
  output logic                    o_dump_valid,
  output logic [NB_ADDR-1:0]      o_dump_addr,
  output logic [MEMORY_WIDTH-1:0] o_dump_data,
  output logic                    o_dump_busy,
  output logic                    o_dump_done,
  // Memory port
  output logic [NB_ADDR-1:0]      o_mem_write_addr,
  output logic [NB_ADDR-1:0]      o_mem_read_addr,
  output logic [MEMORY_WIDTH-1:0] o_mem_data,
  output logic                    o_mem_write_enable,
  output logic                    o_mem_read_enable,
  input  logic [MEMORY_WIDTH-1:0] i_mem_data
);

  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEMORY_DEPTH - 1);

  // Elaboration-time sanity checks on the configuration.
  if (MEMORY_DEPTH > (1 << NB_ADDR)) begin : g_depth_check
    $error("data_memory_arbiter: MEMORY_DEPTH does not fit in NB_ADDR bits");
  end
  if (STARVE_LIMIT < 1) begin : g_starve_check
    $error("data_memory_arbiter: STARVE_LIMIT must be at least 1");
  end

  dump_state_t               state;
  logic [NB_ADDR-1:0]        addr_cnt;
  logic                      cpu_rvalid_q;
  logic                      dump_valid_q;
  logic                      dump_done_q;
  logic [NB_ADDR-1:0]        dump_addr_q;
  logic [MEMORY_WIDTH-1:0]   dump_data_q;

  logic                      dump_req;
  logic                      cpu_grant;
  logic                      dump_grant;

`ifdef DMEM_ARB_FAIR_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0]       starve_cnt;
  logic                      force_dump;

  // Once the CPU has beaten a waiting dump STARVE_LIMIT times in a row,
  // the next cycle goes to the dump regardless of CPU demand.
  assign force_dump = dump_req && (starve_cnt == STARVE_W'(STARVE_LIMIT));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      starve_cnt <= '0;
    end else if (!dump_req || dump_grant) begin
      starve_cnt <= '0;
    end else if (cpu_grant) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Read-port arbitration (combinational, one grant per cycle)
  // --------------------------------------------------------------------------
  always_comb begin
    dump_req = (state == ST_ISSUE);
`ifdef DMEM_ARB_FAIR_EN
    cpu_grant  = i_cpu_read && !force_dump;
    dump_grant = dump_req && (!i_cpu_read || force_dump);
`else
    cpu_grant  = i_cpu_read;
    dump_grant = dump_req && !i_cpu_read;
`endif
  end

  assign o_cpu_stall       = i_cpu_read && !cpu_grant;
  assign o_mem_read_enable = cpu_grant || dump_grant;
  assign o_mem_read_addr   = cpu_grant ? i_cpu_addr : addr_cnt;

  // Write port is the CPU's alone and is never stalled.
  assign o_mem_write_enable = i_cpu_write;
  assign o_mem_write_addr   = i_cpu_addr;
  assign o_mem_data         = i_cpu_wdata;

  // Read data is only meaningful in the cycle after a CPU grant. Gating it
  // also keeps whatever the memory drives right after reset release (when
  // no read has been issued) away from the CPU.
  assign o_cpu_rvalid = cpu_rvalid_q;
  assign o_cpu_rdata  = cpu_rvalid_q ? i_mem_data : '0;

  assign o_dump_valid = dump_valid_q;
  assign o_dump_addr  = dump_addr_q;
  assign o_dump_data  = dump_data_q;
  assign o_dump_done  = dump_done_q;
  assign o_dump_busy  = dump_state_busy(state);

  // --------------------------------------------------------------------------
  // Dump sequencer and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state        <= ST_IDLE;
      addr_cnt     <= '0;
      cpu_rvalid_q <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_done_q  <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
    end else begin
      cpu_rvalid_q <= cpu_grant;
      dump_done_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_dump_start) begin
            addr_cnt <= '0;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (dump_grant) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // The read granted in ISSUE returns its data now.
          dump_data_q  <= i_mem_data;
          dump_addr_q  <= addr_cnt;
          dump_valid_q <= 1'b1;
          state        <= ST_HOLD;
        end
        ST_HOLD: begin
          if (i_dump_ready) begin
            dump_valid_q <= 1'b0;
            if (addr_cnt == LAST_ADDR) begin
              dump_done_q <= 1'b1;
              state       <= ST_DONE;
            end else begin
              addr_cnt <= addr_cnt + NB_ADDR'(1);
              state    <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : data_memory_arbiter
`default_nettype wire

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 SHALL have parameters: MEMORY_WIDTH, default 32, data word width; NB_ADDR, default 7, address width; MEMORY_DEPTH, default 128, words in memory; STARVE_LIMIT, default 4, consecutive CPU read wins before dump is forced.
REQ-002 SHALL have ports: i_clock  in  1  single clock; i_reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have CPU port: i_cpu_read in 1; i_cpu_write in 1; i_cpu_addr in NB_ADDR; i_cpu_wdata in MEMORY_WIDTH; o_cpu_stall out 1; o_cpu_rdata out MEMORY_WIDTH; o_cpu_rvalid out 1.
REQ-004 SHALL have dump port: i_dump_start in 1; i_dump_ready in 1; o_dump_valid out 1; o_dump_addr out NB_ADDR; o_dump_data out MEMORY_WIDTH; o_dump_busy out 1; o_dump_done out 1.
REQ-005 SHALL have memory port: o_mem_write_addr out NB_ADDR; o_mem_read_addr out NB_ADDR; o_mem_data out MEMORY_WIDTH; o_mem_write_enable out 1; o_mem_read_enable out 1; i_mem_data in MEMORY_WIDTH (memory has a registered read with 1-cycle latency).

Function
REQ-006 SHALL dedicate the write port to the CPU: o_mem_write_enable = i_cpu_write, o_mem_write_addr = i_cpu_addr, o_mem_data = i_cpu_wdata, combinational, never stalled.
REQ-007 SHALL arbitrate only the read port between a CPU read and a dump read, one grant per cycle, driven combinationally.
REQ-008 SHALL, by default, give the CPU fixed priority; o_cpu_stall = i_cpu_read AND NOT CPU grant, combinational.
REQ-009 SHALL, on a CPU grant in cycle N, drive o_mem_read_enable=1 and o_mem_read_addr=i_cpu_addr in N, then in N+1 assert o_cpu_rvalid for one cycle with o_cpu_rdata=i_mem_data.
REQ-010 SHALL deliver old data on a same-cycle CPU read and write to the same address (memory is read-first), with no forwarding.
REQ-011 SHALL implement a dump FSM: IDLE, ISSUE, CAPTURE, HOLD, DONE.
REQ-012 IDLE: on i_dump_start, clear the address counter to 0 and go to ISSUE; o_dump_busy=0.
REQ-013 ISSUE: request the read port at the counter address; on grant go to CAPTURE, otherwise stay.
REQ-014 CAPTURE: register i_mem_data into o_dump_data and the counter into o_dump_addr, then go to HOLD.
REQ-015 HOLD: hold o_dump_valid=1 with stable data/addr until i_dump_ready=1; on handshake, if the counter equals MEMORY_DEPTH-1 go to DONE, else increment the counter and go to ISSUE.
REQ-016 DONE: pulse o_dump_done for one cycle and return to IDLE; o_dump_busy=1 in ISSUE, CAPTURE and HOLD.
REQ-017 SHALL ignore i_dump_start outside IDLE.
REQ-018 SHALL keep at most one dump read outstanding; the counter never wraps past MEMORY_DEPTH-1.

Reset
REQ-019 SHALL, on i_reset low, immediately force the FSM to IDLE and clear the counter, starvation counter, o_cpu_rvalid, o_dump_valid, o_dump_done, o_dump_data and o_dump_addr to 0, including mid-dump; any in-flight read is discarded.
REQ-020 SHALL ignore i_mem_data in the first cycle after reset release.

Configuration
REQ-021 SHALL support the macro DMEM_ARB_FAIR_EN.
REQ-022 With DMEM_ARB_FAIR_EN defined: count consecutive cycles in which the CPU wins while the FSM is in ISSUE; at STARVE_LIMIT, grant the dump next cycle (CPU stalled) and clear the count; the count also clears whenever the FSM leaves ISSUE.
REQ-023 Without DMEM_ARB_FAIR_EN: strict CPU priority, no starvation counter logic is present, and the dump may starve indefinitely.

Structure
REQ-024 SHALL place the dump FSM state encoding and the default width/depth constants in the shared package.
REQ-025 SHALL be flat; no sub-module is needed (the memory is instantiated by the parent beside this block).

Verification
REQ-026 CPU read addr 5 (mem[5]=0xDEADBEEF), no dump -> mem read enable in N, o_cpu_rvalid=1 with 0xDEADBEEF in N+1, stall=0.
REQ-027 CPU write addr 3 data 0x1234 plus read addr 3 in the same cycle -> write enable=1, rdata = old mem[3]; a next-cycle read returns 0x1234.
REQ-028 Dump start, i_dump_ready=1 throughout, no CPU traffic -> 128 valid handshakes, addresses 0..127 in order, data matching memory, one o_dump_done pulse, then busy=0.
REQ-029 Dump in HOLD at addr 10 with i_dump_ready=0 for 5 cycles -> valid, addr and data stable; advances to addr 11 only after ready=1.
REQ-030 CPU reads every cycle during a dump -> without the macro, the dump stays in ISSUE; with DMEM_ARB_FAIR_EN, the dump is granted on the 5th cycle and o_cpu_stall=1 exactly that cycle.
REQ-031 Assert i_reset low while in HOLD at addr 40 -> all outputs 0 immediately, FSM in IDLE; a new start dumps from addr 0.
